// File: rtl/knight_cmd_link.sv
// Knight-side UART endpoint: 8N1 receiver, high/low byte-pair command assembler
// and 8N1 response transmitter, with independent RX and TX paths.
//
// state         | meaning
// RX_IDLE       | line idle, waiting for a falling edge
// RX_START      | half-bit wait to confirm the start bit
// RX_DATA       | sampling 8 data bits, LSB first
// RX_STOP       | sampling the stop bit
// ASM_WAIT_HI   | waiting for the command high byte
// ASM_WAIT_LO   | high byte held, waiting for the low byte under timeout
// TX_IDLE       | TX high, waiting for trmt
// TX_XMIT       | shifting out start, 8 data and stop bits
module knight_cmd_link #(
  parameter int BAUD_DIV = 2604,
  parameter int BYTE_TMO = 2**20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        frm_err,
  output logic        overrun
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int TW = $clog2(BYTE_TMO + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(BYTE_TMO);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [0:0] ASM_WAIT_HI = 1'b0;
  localparam logic [0:0] ASM_WAIT_LO = 1'b1;

  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_XMIT = 1'b1;

  logic          rx_meta, rx_sync, rx_prev;
  logic [1:0]    rx_state;
  logic [BW-1:0] rx_baud;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_fall, stop_smp, byte_vld, byte_bad;

  logic [0:0]    asm_state;
  logic [7:0]    hi_byte;
  logic [TW-1:0] tmo_cnt;

  logic [0:0]    tx_state;
  logic [BW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;

  // Sync flops reset high so a reset never looks like a start-bit edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall  = rx_prev & ~rx_sync;
  assign stop_smp = (rx_state == RX_STOP) && (rx_baud == BAUD_LAST);
  assign byte_vld = stop_smp & rx_sync;
  assign byte_bad = stop_smp & ~rx_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      frm_err  <= 1'b0;
    end else begin
      frm_err <= byte_bad;
      case (rx_state)
        RX_IDLE: begin
          rx_baud <= '0;
          rx_bit  <= '0;
          if (rx_fall) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_baud == HALF_LAST) begin
            rx_baud  <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_baud == BAUD_LAST) begin
            rx_baud  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_baud == BAUD_LAST) begin
            rx_baud  <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_baud <= rx_baud + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Completion is written after the clear so it wins on a same-cycle ack
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_state <= ASM_WAIT_HI;
      hi_byte   <= '0;
      tmo_cnt   <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      case (asm_state)
        ASM_WAIT_HI: begin
          if (byte_vld) begin
            hi_byte   <= rx_shift;
            tmo_cnt   <= TMO_LOAD;
            asm_state <= ASM_WAIT_LO;
          end
        end
        ASM_WAIT_LO: begin
          if (byte_vld) begin
            cmd       <= {hi_byte, rx_shift};
            cmd_rdy   <= 1'b1;
            overrun   <= cmd_rdy;
            asm_state <= ASM_WAIT_HI;
          end else if (byte_bad || (tmo_cnt == '0)) begin
            asm_state <= ASM_WAIT_HI;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        default: asm_state <= ASM_WAIT_HI;
      endcase
    end
  end

  // tx_shift holds the bits still to send after the current one, stop bit on top
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
      TX       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (trmt) begin
            tx_shift <= {1'b1, resp};
            TX       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_state <= TX_XMIT;
          end
        end
        TX_XMIT: begin
          if (tx_baud == BAUD_LAST) begin
            tx_baud <= '0;
            if (tx_bit == 4'd9) begin
              TX       <= 1'b1;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              TX       <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[8:1]};
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_baud <= tx_baud + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knight_cmd_link.sv
// Self-checking bench for knight_cmd_link: serial stimulus on RX, frame decode
// on TX, expected values taken from the commands and responses the bench sends.
module tb_knight_cmd_link;
  localparam int BAUD_DIV = 16;
  localparam int BYTE_TMO = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        trmt = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        TX, cmd_rdy, tx_busy, tx_done, frm_err, overrun;
  logic [15:0] cmd;

  int checks = 0;
  int errors = 0;
  int n_frm = 0, n_ovr = 0, n_done = 0;

  knight_cmd_link #(.BAUD_DIV(BAUD_DIV), .BYTE_TMO(BYTE_TMO)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_busy(tx_busy),
    .tx_done(tx_done), .frm_err(frm_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frm_err) n_frm++;
    if (overrun) n_ovr++;
    if (tx_done) n_done++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
    RX = stop_bit;
    repeat (BAUD_DIV) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic send_cmd(input logic [15:0] v, input int gap);
    send_byte(v[15:8], 1'b1);
    repeat (gap) @(negedge clk);
    send_byte(v[7:0], 1'b1);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({TX, cmd_rdy, tx_busy, tx_done, frm_err, overrun} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: got TX/rdy/busy/done/frm/ovr=%b want 100000",
               {TX, cmd_rdy, tx_busy, tx_done, frm_err, overrun});
    end
    checks++;
    if (cmd !== 16'h0000) begin
      errors++;
      $display("FAIL reset_cmd: got %h want 0000", cmd);
    end
  endtask

  task automatic test_loop();
    send_cmd(16'h6033, 0);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h6033) begin
      errors++;
      $display("FAIL loop_6033: got rdy=%b cmd=%h want rdy=1 cmd=6033", cmd_rdy, cmd);
    end
    pulse_clr();
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h6033) begin
      errors++;
      $display("FAIL clr_hold: got rdy=%b cmd=%h want rdy=0 cmd=6033", cmd_rdy, cmd);
    end
    repeat (2 * BAUD_DIV) @(negedge clk);
    send_cmd(16'h2000, 5);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h2000) begin
      errors++;
      $display("FAIL loop_2000: got rdy=%b cmd=%h want rdy=1 cmd=2000", cmd_rdy, cmd);
    end
    pulse_clr();
  endtask

  // Frame expectation comes straight from the 8N1 definition: 0, data LSB first, 1
  task automatic test_tx_frame(input logic [7:0] r);
    int   d0;
    logic exp_bit;
    logic saw_low;
    d0 = n_done;
    resp = r;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    resp = 8'($urandom);
    repeat (BAUD_DIV / 2 - 1) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      exp_bit = 1'b0;
      else if (i == 9) exp_bit = 1'b1;
      else             exp_bit = r[i-1];
      checks++;
      if (TX !== exp_bit) begin
        errors++;
        $display("FAIL tx_bit%0d resp=%h: got %b want %b", i, r, TX, exp_bit);
      end
      if (i == 4) begin
        checks++;
        if (tx_busy !== 1'b1) begin
          errors++;
          $display("FAIL tx_busy_mid: got %b want 1", tx_busy);
        end
        resp = ~r;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        repeat (BAUD_DIV - 1) @(negedge clk);
      end else if (i < 9) begin
        repeat (BAUD_DIV) @(negedge clk);
      end
    end
    saw_low = 1'b0;
    repeat (4 * BAUD_DIV) begin
      @(negedge clk);
      if (TX !== 1'b1) saw_low = 1'b1;
    end
    checks++;
    if (n_done - d0 != 1 || saw_low !== 1'b0 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL tx_end resp=%h: got done_pulses=%0d extra_low=%b busy=%b want 1 0 0",
               r, n_done - d0, saw_low, tx_busy);
    end
  endtask

  task automatic test_tx();
    test_tx_frame(8'hA5);
    for (int k = 0; k < 3; k++) test_tx_frame(8'($urandom));
  endtask

  task automatic test_full_duplex();
    logic [15:0] v;
    v = 16'($urandom);
    fork
      test_tx_frame(8'($urandom));
      send_cmd(v, 3);
    join
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== v) begin
      errors++;
      $display("FAIL duplex_cmd: got rdy=%b cmd=%h want rdy=1 cmd=%h", cmd_rdy, cmd, v);
    end
    pulse_clr();
  endtask

  task automatic test_frm_err();
    int d0;
    d0 = n_frm;
    send_byte(8'h40, 1'b0);
    repeat (2 * BAUD_DIV) @(negedge clk);
    checks++;
    if (n_frm - d0 != 1 || cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL frm_err_hi: got pulses=%0d rdy=%b want 1 0", n_frm - d0, cmd_rdy);
    end
    send_cmd(16'h4122, 0);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h4122) begin
      errors++;
      $display("FAIL after_frm: got rdy=%b cmd=%h want rdy=1 cmd=4122", cmd_rdy, cmd);
    end
    pulse_clr();
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b0);
    repeat (2 * BAUD_DIV) @(negedge clk);
    send_cmd(16'h0F1E, 0);
    checks++;
    if (cmd !== 16'h0F1E || n_frm - d0 != 2) begin
      errors++;
      $display("FAIL frm_err_lo: got cmd=%h pulses=%0d want 0f1e 2", cmd, n_frm - d0);
    end
    pulse_clr();
  endtask

  task automatic test_timeout();
    send_byte(8'h60, 1'b1);
    repeat (BYTE_TMO + 10) @(negedge clk);
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_rdy: got %b want 0", cmd_rdy);
    end
    send_cmd(16'h1234, 0);
    checks++;
    if (cmd !== 16'h1234) begin
      errors++;
      $display("FAIL tmo_cmd: got %h want 1234", cmd);
    end
    pulse_clr();
  endtask

  task automatic test_random_cmds();
    logic [15:0] v;
    for (int k = 0; k < 5; k++) begin
      v = 16'($urandom);
      send_cmd(v, int'($urandom_range(0, 3 * BAUD_DIV)));
      checks++;
      if (cmd_rdy !== 1'b1 || cmd !== v) begin
        errors++;
        $display("FAIL rand_cmd%0d: got rdy=%b cmd=%h want rdy=1 cmd=%h", k, cmd_rdy, cmd, v);
      end
      pulse_clr();
      checks++;
      if (cmd_rdy !== 1'b0 || cmd !== v) begin
        errors++;
        $display("FAIL rand_clr%0d: got rdy=%b cmd=%h want rdy=0 cmd=%h", k, cmd_rdy, cmd, v);
      end
      repeat ($urandom_range(1, 2 * BAUD_DIV)) @(negedge clk);
    end
  endtask

  task automatic test_clr_race();
    send_byte(8'hC7, 1'b1);
    fork
      send_byte(8'h19, 1'b1);
      begin
        clr_cmd_rdy = 1'b1;
        for (int k = 0; k < 12 * BAUD_DIV && cmd_rdy !== 1'b1; k++) @(negedge clk);
        clr_cmd_rdy = 1'b0;
      end
    join
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'hC719) begin
      errors++;
      $display("FAIL clr_race: got rdy=%b cmd=%h want rdy=1 cmd=c719", cmd_rdy, cmd);
    end
    pulse_clr();
  endtask

  task automatic test_overrun();
    int d0;
    logic [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    d0 = n_ovr;
    send_cmd(a, 0);
    checks++;
    if (n_ovr != d0) begin
      errors++;
      $display("FAIL ovr_first: got pulses=%0d want 0", n_ovr - d0);
    end
    send_cmd(b, 2);
    checks++;
    if (n_ovr - d0 != 1 || cmd !== b || cmd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL ovr_second: got pulses=%0d cmd=%h rdy=%b want 1 %h 1",
               n_ovr - d0, cmd, cmd_rdy, b);
    end
  endtask

  task automatic test_rst_mid_byte();
    send_byte(8'h77, 1'b1);
    resp = 8'h3C;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    RX = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    RX = 1'b1;
    repeat (BAUD_DIV) @(negedge clk);
    RX = 1'b0;
    repeat (BAUD_DIV + 3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    RX = 1'b1;
    checks++;
    if ({TX, cmd_rdy, tx_busy, tx_done, frm_err, overrun} !== 6'b100000 || cmd !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid: got TX/rdy/busy/done/frm/ovr=%b cmd=%h want 100000 0000",
               {TX, cmd_rdy, tx_busy, tx_done, frm_err, overrun}, cmd);
    end
    repeat (12 * BAUD_DIV) @(negedge clk);
    send_cmd(16'h5AC3, 0);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h5AC3) begin
      errors++;
      $display("FAIL rst_recover: got rdy=%b cmd=%h want rdy=1 cmd=5ac3", cmd_rdy, cmd);
    end
  endtask

  initial begin
    test_reset();
    test_loop();
    test_tx();
    test_full_duplex();
    test_frm_err();
    test_timeout();
    test_random_cmds();
    test_clr_race();
    test_overrun();
    test_rst_mid_byte();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
